// File: rtl/memy_access_ctrl_if.sv
// Bundles the request, write-beat, response and MemY strobe/data signals of the MemY initiator.
// The master modport is the controller's view; the slave modport is the sequencer/MemY side.
interface memy_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [7:0]  req_len;

    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;

    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;

    logic        busy;

    logic [7:0]  common_address;
    logic [31:0] A;
    logic [31:0] B;
    logic        WrtEnbY;
    logic        notWrtEnbY;
    logic [63:0] memY_dataout;

    modport master (
        input  req_valid, req_write, req_addr, req_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        input  memY_dataout,
        output req_ready, wr_ready,
        output rd_valid, rd_data,
        output busy,
        output common_address, A, B, WrtEnbY, notWrtEnbY
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len,
        output wr_valid, wr_data,
        output rd_ready,
        output memY_dataout,
        input  req_ready, wr_ready,
        input  rd_valid, rd_data,
        input  busy,
        input  common_address, A, B, WrtEnbY, notWrtEnbY
    );
endinterface

// File: rtl/memy_access_ctrl.sv
// MemY initiator: turns burst requests into per-beat MemY write/read strobes and
// collects returned read words into a credit-protected response FIFO.
module memy_access_ctrl #(
    parameter int READ_LAT   = 1,
    parameter int RESP_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    memy_access_ctrl_if.master  bus
);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [CW:0]   DepthC   = (CW + 1)'(RESP_DEPTH);
    localparam logic [PW-1:0] LastPtrC = PW'(RESP_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t        state_q;
    logic [7:0]    addr_q;
    logic [7:0]    beatsLeft_q;
    logic          resetDone_q;
    logic [7:0]    commonAddress_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic          wrtEnb_q;
    logic          notWrtEnb_q;
    logic [READ_LAT-1:0] tag_q;

    logic [63:0]   fifoMem_q [RESP_DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] fifoCount_q, fifoCount_d;

    logic [CW:0]   inFlight;
    logic [CW:0]   credit;
    logic          accept;
    logic          rdIssue;
    logic          push;
    logic          pop;
    logic          rdValid;

    // Credit covers the strobe just issued plus every tag still in the return pipe,
    // so a read is only issued when a FIFO slot is guaranteed for its data.
    always_comb begin
        inFlight = {{CW{1'b0}}, notWrtEnb_q};
        for (int i = 0; i < READ_LAT; i++) begin
            inFlight = inFlight + {{CW{1'b0}}, tag_q[i]};
        end
        credit  = inFlight + {1'b0, fifoCount_q};
        accept  = (state_q == IDLE) && resetDone_q && bus.req_valid;
        rdIssue = (state_q == READ) && (credit < DepthC);
        rdValid = (fifoCount_q != '0);
        push    = tag_q[READ_LAT-1];
        pop     = rdValid && bus.rd_ready;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            beatsLeft_q     <= '0;
            resetDone_q     <= 1'b0;
            commonAddress_q <= '0;
            a_q             <= '0;
            b_q             <= '0;
            wrtEnb_q        <= 1'b0;
            notWrtEnb_q     <= 1'b0;
        end else begin
            resetDone_q <= 1'b1;
            wrtEnb_q    <= 1'b0;
            notWrtEnb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q      <= bus.req_addr;
                        beatsLeft_q <= bus.req_len;
                        state_q     <= bus.req_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (bus.wr_valid) begin
                        wrtEnb_q        <= 1'b1;
                        commonAddress_q <= addr_q;
                        a_q             <= bus.wr_data[63:32];
                        b_q             <= bus.wr_data[31:0];
                        addr_q          <= addr_q + 8'd1;
                        beatsLeft_q     <= beatsLeft_q - 8'd1;
                        if (beatsLeft_q == 8'd0) state_q <= IDLE;
                    end
                end
                READ: begin
                    if (rdIssue) begin
                        notWrtEnb_q     <= 1'b1;
                        commonAddress_q <= addr_q;
                        addr_q          <= addr_q + 8'd1;
                        beatsLeft_q     <= beatsLeft_q - 8'd1;
                        if (beatsLeft_q == 8'd0) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag pipe is aligned so its last stage is high exactly when memY_dataout holds the word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= notWrtEnb_q;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        fifoCount_d = fifoCount_q;
        if (push) wrPtr_d = (wrPtr_q == LastPtrC) ? '0 : wrPtr_q + PW'(1);
        if (pop)  rdPtr_d = (rdPtr_q == LastPtrC) ? '0 : rdPtr_q + PW'(1);
        if (push && !pop)      fifoCount_d = fifoCount_q + CW'(1);
        else if (pop && !push) fifoCount_d = fifoCount_q - CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            fifoCount_q <= fifoCount_d;
        end
    end

    // Storage needs no reset: rd_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) fifoMem_q[wrPtr_q] <= bus.memY_dataout;
    end

    assign bus.req_ready      = (state_q == IDLE) && resetDone_q;
    assign bus.wr_ready       = (state_q == WRITE);
    assign bus.rd_valid       = rdValid;
    assign bus.rd_data        = rdValid ? fifoMem_q[rdPtr_q] : 64'd0;
    assign bus.busy           = (state_q != IDLE) || (inFlight != '0) || rdValid;
    assign bus.common_address = commonAddress_q;
    assign bus.A              = a_q;
    assign bus.B              = b_q;
    assign bus.WrtEnbY        = wrtEnb_q;
    assign bus.notWrtEnbY     = notWrtEnb_q;

endmodule

// File: tb/tb_memy_access_ctrl.sv
// Directed testbench for memy_access_ctrl with a behavioural MemY SRAM behind the strobes.
// Inputs change 1 time unit after a rising edge; monitors sample on the falling edge.
module tb_memy_access_ctrl;

    localparam int READ_LAT   = 1;
    localparam int RESP_DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    memy_access_ctrl_if bus();

    memy_access_ctrl #(
        .READ_LAT   (READ_LAT),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [63:0] sram [256];
    logic [63:0] wrTbl [16];
    logic [7:0]  wrAddrQ [$];
    logic [63:0] wrDataQ [$];
    logic [63:0] rdQ [$];
    int          rdStrobes;
    int          overlapCnt;
    int          checkCount;
    int          passCount;

    // Single-cycle-latency synchronous SRAM model matching READ_LAT = 1.
    always @(posedge clock) begin
        if (bus.WrtEnbY)    sram[bus.common_address] <= {bus.A, bus.B};
        if (bus.notWrtEnbY) bus.memY_dataout <= sram[bus.common_address];
    end

    always @(negedge clock) begin
        if (bus.WrtEnbY) begin
            wrAddrQ.push_back(bus.common_address);
            wrDataQ.push_back({bus.A, bus.B});
        end
        if (bus.notWrtEnbY) rdStrobes++;
        if (bus.WrtEnbY && bus.notWrtEnbY) overlapCnt++;
        if (bus.rd_valid && bus.rd_ready) rdQ.push_back(bus.rd_data);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] patData(input int k);
        return {32'hC0DE_0000 | 32'(k), 32'h5A5A_0000 | 32'(k * 16)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic write, input logic [7:0] addr, input logic [7:0] len);
        int n = 0;
        while (!bus.req_ready && n < 200) begin
            tick();
            n++;
        end
        checkOutput("req_ready_before_accept", 64'(bus.req_ready), 64'd1);
        bus.req_write = write;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic writeBurst(input int n, input int gapAt, input int gapLen);
        int i = 0;
        int guard = 0;
        int gapDone = 0;
        logic xfer;
        while (i < n && guard < 1000) begin
            if (i == gapAt && gapDone < gapLen) begin
                bus.wr_valid = 1'b0;
                tick();
                gapDone++;
                checkOutput("wrtenb_in_gap", 64'(bus.WrtEnbY), 64'd0);
            end else begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = wrTbl[i];
                xfer = bus.wr_ready;
                tick();
                if (xfer) i++;
            end
            guard++;
        end
        bus.wr_valid = 1'b0;
        checkOutput("write_beats_sent", 64'(i), 64'(n));
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (bus.busy && n < 1000) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int lat;
        int guard;
        logic [7:0] wrapAddr [4];

        checkCount = 0;
        passCount  = 0;
        rdStrobes  = 0;
        overlapCnt = 0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd0;
        bus.req_len   = 8'd0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 64'd0;
        bus.rd_ready  = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        tick();

        $display("[TB] test 1: reset during a read burst");
        applyStimulus(1'b0, 8'h40, 8'd7);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_WrtEnbY",        64'(bus.WrtEnbY),        64'd0);
        checkOutput("rst_notWrtEnbY",     64'(bus.notWrtEnbY),     64'd0);
        checkOutput("rst_common_address", 64'(bus.common_address), 64'd0);
        checkOutput("rst_A",              64'(bus.A),              64'd0);
        checkOutput("rst_B",              64'(bus.B),              64'd0);
        checkOutput("rst_rd_valid",       64'(bus.rd_valid),       64'd0);
        checkOutput("rst_rd_data",        bus.rd_data,             64'd0);
        checkOutput("rst_req_ready",      64'(bus.req_ready),      64'd0);
        checkOutput("rst_wr_ready",       64'(bus.wr_ready),       64'd0);
        checkOutput("rst_busy",           64'(bus.busy),           64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        tick();
        checkOutput("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("post_rst_busy",      64'(bus.busy),      64'd0);
        checkOutput("post_rst_rd_valid",  64'(bus.rd_valid),  64'd0);
        rdQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();

        $display("[TB] test 2: 4-beat write at 0x10");
        wrTbl[0] = 64'h1111_0000_B000_0000;
        wrTbl[1] = 64'h2222_0001_B000_0001;
        wrTbl[2] = 64'h3333_0002_B000_0002;
        wrTbl[3] = 64'h4444_0003_B000_0003;
        applyStimulus(1'b1, 8'h10, 8'd3);
        writeBurst(4, -1, 0);
        tick();
        checkOutput("wr_pulse_count", 64'(wrAddrQ.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("wr_address", 64'(wrAddrQ[k]), 64'(8'h10 + 8'(k)));
            checkOutput("wr_data_AB", wrDataQ[k], wrTbl[k]);
        end
        checkOutput("wr_back_to_idle", 64'(bus.req_ready), 64'd1);

        $display("[TB] test 3: 4-beat read at 0x10");
        rdQ.delete();
        bus.rd_ready = 1'b1;
        applyStimulus(1'b0, 8'h10, 8'd3);
        lat = 0;
        while (!bus.rd_valid && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput("first_rd_valid_latency", 64'(lat), 64'(READ_LAT + 2));
        waitIdle("rd_idle");
        checkOutput("rd_word_count", 64'(rdQ.size()), 64'd4);
        for (int k = 0; k < 4; k++) checkOutput("rd_word", rdQ[k], wrTbl[k]);

        $display("[TB] test 4: address wrap");
        wrTbl[0] = 64'hAAAA_00FE_0000_0001;
        wrTbl[1] = 64'hAAAA_00FF_0000_0002;
        wrTbl[2] = 64'hAAAA_0100_0000_0003;
        wrTbl[3] = 64'hAAAA_0101_0000_0004;
        wrapAddr[0] = 8'hFE;
        wrapAddr[1] = 8'hFF;
        wrapAddr[2] = 8'h00;
        wrapAddr[3] = 8'h01;
        wrAddrQ.delete();
        wrDataQ.delete();
        applyStimulus(1'b1, 8'hFE, 8'd3);
        writeBurst(4, -1, 0);
        tick();
        checkOutput("wrap_pulse_count", 64'(wrAddrQ.size()), 64'd4);
        for (int k = 0; k < 4; k++) checkOutput("wrap_address", 64'(wrAddrQ[k]), 64'(wrapAddr[k]));
        rdQ.delete();
        applyStimulus(1'b0, 8'h00, 8'd0);
        waitIdle("wrap_rd_idle");
        checkOutput("wrap_rd_count", 64'(rdQ.size()), 64'd1);
        checkOutput("wrap_rd_beat3", rdQ[0], 64'hAAAA_0100_0000_0003);

        $display("[TB] test 6: write burst with a 3-cycle wr_valid gap");
        for (int k = 0; k < 16; k++) wrTbl[k] = patData(k);
        wrAddrQ.delete();
        wrDataQ.delete();
        applyStimulus(1'b1, 8'h10, 8'd15);
        writeBurst(16, 5, 3);
        tick();
        checkOutput("stall_pulse_count", 64'(wrAddrQ.size()), 64'd16);
        for (int k = 0; k < 16; k++) begin
            checkOutput("stall_address", 64'(wrAddrQ[k]), 64'(8'h10 + 8'(k)));
            checkOutput("stall_data",    wrDataQ[k],      patData(k));
        end

        $display("[TB] test 5: 16-beat read with back-pressure");
        bus.rd_ready = 1'b0;
        rdQ.delete();
        rdStrobes = 0;
        applyStimulus(1'b0, 8'h10, 8'd15);
        repeat (20) tick();
        checkOutput("bp_strobes_when_stalled", 64'(rdStrobes), 64'(RESP_DEPTH));
        checkOutput("bp_rd_valid",             64'(bus.rd_valid),   64'd1);
        checkOutput("bp_no_strobe",            64'(bus.notWrtEnbY), 64'd0);
        checkOutput("bp_busy",                 64'(bus.busy),       64'd1);
        guard = 0;
        while (rdQ.size() < 16 && guard < 2000) begin
            bus.rd_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        bus.rd_ready = 1'b0;
        waitIdle("bp_idle");
        checkOutput("bp_word_count",   64'(rdQ.size()), 64'd16);
        checkOutput("bp_strobe_total", 64'(rdStrobes),  64'd16);
        for (int k = 0; k < 16; k++) checkOutput("bp_word", rdQ[k], patData(k));
        checkOutput("bp_fifo_drained", 64'(bus.rd_valid), 64'd0);

        checkOutput("strobe_overlap", 64'(overlapCnt), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
